p4bd_serializer: RTL and testbench
==================================

# p4bd_serializer

Clocked parallel-to-serial stage feeding the 1-bit sequence-detector FSM. Accepts a WIDTH-bit word on a valid/ready port and emits it one bit at a time on a 4-phase bundled-data channel (out_req/out_ack/out_data). The asynchronous out_ack input passes through a SYNC_STAGES flop synchronizer. This block is the synthesizable replacement for the behavioural data generator that drives the FSM's input channel.

## Interface
- WIDTH, 13: bits per input word.
- SYNC_STAGES, 2: flops in the out_ack synchronizer (≥2).
- LSB_FIRST, 1: 1 = bit 0 sent first; 0 = bit WIDTH-1 sent first.

- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  word to serialize.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word.
- out_data  out  1  current bit; bundled with out_req.
- out_req  out  1  4-phase request.
- out_ack  in  1  4-phase acknowledge from the FSM; asynchronous.
- busy  out  1  word in progress (state ≠ IDLE).
- word_done  out  1  one-cycle pulse after the last bit's return-to-zero.

## Operation
- All outputs are registered. While reset is high, on each edge: state=IDLE, out_req=0, out_data=0, busy=0, word_done=0, in_ready=0, synchronizer flops=0, bit counter=0. in_ready=1 from the first edge with reset low.
- Synchronizer: ack_s is the last flop of a SYNC_STAGES chain clocked by clk. The FSM uses only ack_s.
- Word accept: at an edge where in_valid && in_ready:
  - Latch in_data into the shift register.
  - Counter = WIDTH-1.
  - Go to SETUP. in_ready=0, busy=1.
- States:
  - IDLE: in_ready=1, out_req=0. Waits for an accept.
  - SETUP:
    - out_data = current bit, out_req=0.
    - If ack_s==0, go to REQ_HI at the next edge.
    - Otherwise stay in SETUP. This guards a channel left with ack high after reset.
  - REQ_HI: out_req=1, out_data held. When ack_s==1 is sampled, go to WAIT_LO at the next edge.
  - WAIT_LO: out_req=0, out_data held. When ack_s==0 is sampled:
    - If counter>0: shift, decrement the counter, go to SETUP with the next bit.
    - If counter==0: go to IDLE, assert word_done for one cycle, busy=0, in_ready=1.
- out_data changes only on entry to SETUP, when out_req=0 and ack_s=0. This satisfies the bundled-data constraint that data is stable at least one cycle before the req rising edge and until ack falls.
- in_valid is ignored outside IDLE. in_data is sampled only at accept.
- Reset mid-word:
  - The word is dropped and out_req falls at the reset edge.
  - No word_done pulse is produced.
  - The next word waits in SETUP until the synchronized ack is low.

## Timing
- Accept at edge T, then:
  - SETUP for bit 0 during the cycle after T.
  - out_req rises after edge T+1.
- With a responder whose ack follows req within the same cycle and SYNC_STAGES=S:
  - REQ_HI lasts S+1 cycles.
  - WAIT_LO lasts S+1 cycles.
  - Bit period = 2S+3 cycles (7 for S=2).
- A word finishes at edge T + WIDTH·(2S+3); word_done is high for the cycle after that edge (T+91 for the defaults).
- Back-to-back words:
  - in_ready is high for the IDLE cycle coinciding with word_done.
  - A word accepted there enters SETUP next.
  - Minimum inter-word gap is 1 cycle.
- Slow ack only stretches REQ_HI/WAIT_LO; there is no timeout.

## Test plan
- Reset, then idle: hold reset 3 cycles -> during reset out_req=0, busy=0, in_ready=0; in_ready=1 after the first unreset edge; no out_req activity while in_valid=0.
- Default word 13'b1101001101101, LSB_FIRST=1, instant responder -> received bits 1,0,1,1,0,1,1,0,0,1,0,1,1; out_req rises 13 times; word_done one cycle, 91 cycles after accept.
- Bundled-data check, responder with random 1–10 cycle delays on both edges -> out_data never changes while out_req=1 or ack_s=1; out_data stable ≥1 cycle before each out_req rise; every out_req fall follows an ack rise; same 13-bit sequence.
- Back-to-back: in_valid held high with words 13'h1FFF then 13'h0000 -> second accept in the word_done cycle; 13 ones then 13 zeros; busy low for exactly 1 cycle between words.
- Reset mid-word: reset asserted after bit 5, while in REQ_HI with ack high -> out_req=0 next edge, no word_done. Then hold ack high 10 cycles and send 13'h0001 -> block stays in SETUP with out_req=0 until ack_s=0, then delivers 1 followed by twelve 0s.
- LSB_FIRST=0, WIDTH=4, word 4'b1000, SYNC_STAGES=3 -> bits 1,0,0,0; bit period 9 cycles with the instant responder.

Source files
------------

// File: rtl/p4bd_serializer.sv
// p4bd_serializer
// Parallel-to-serial stage: takes a WIDTH-bit word on a valid/ready port and
// sends it one bit at a time over a 4-phase bundled-data channel
// (out_req/out_ack/out_data). out_ack is asynchronous and is only ever looked
// at through a SYNC_STAGES flop synchronizer (ack_s).
module p4bd_serializer #(
    parameter int WIDTH       = 13,
    parameter int SYNC_STAGES = 2,
    parameter bit LSB_FIRST   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_data,
    output logic             out_req,
    input  logic             out_ack,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_REQ_HI  = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       shift_q, shift_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   data_q, data_d;
    logic                   req_q, req_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;

    // Bit that goes on the wire first for a given shift-register content.
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        if (LSB_FIRST) begin
            return w[0];
        end else begin
            return w[WIDTH-1];
        end
    endfunction

    // Discard the bit just sent, bringing the next one to the lead position.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        if (LSB_FIRST) begin
            return {1'b0, w[WIDTH-1:1]};
        end else begin
            return {w[WIDTH-2:0], 1'b0};
        end
    endfunction

    // Synchronizer chain for the asynchronous acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], out_ack};
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    // Next-state and next-output logic; out_data only moves on entry to SETUP
    // (or at accept), where both req and the synchronized ack are low.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && ready_q) begin
                    state_d = ST_SETUP;
                    shift_d = in_data;
                    cnt_d   = CW'(WIDTH - 1);
                    data_d  = lead_bit(in_data);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                // Hold off the request until a stale high ack has drained.
                if (!ack_s) begin
                    state_d = ST_REQ_HI;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_REQ_HI: begin
                if (ack_s) begin
                    state_d = ST_WAIT_LO;
                end else begin
                    state_d = ST_REQ_HI;
                end
            end
            ST_WAIT_LO: begin
                if (!ack_s) begin
                    if (cnt_q != '0) begin
                        state_d = ST_SETUP;
                        shift_d = shift_word(shift_q);
                        cnt_d   = cnt_q - 1'b1;
                        data_d  = lead_bit(shift_word(shift_q));
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_WAIT_LO;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d   = (state_d == ST_REQ_HI);
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and registered-output flops; reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= 1'b0;
            req_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_data  = data_q;
    assign out_req   = req_q;
    assign busy      = busy_q;
    assign word_done = done_q;

endmodule

// File: tb/tb_p4bd_serializer.sv
// Self-checking bench for p4bd_serializer: a default instance (13 bits,
// 2 sync stages, LSB first) and a small one (4 bits, 3 stages, MSB first).
// Expected bits are queued when a word is driven and popped on each out_req rise.
module tb_p4bd_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;

    // Instance A signals
    logic [12:0] in_data_a;
    logic        in_valid_a;
    logic        in_ready_a, out_data_a, out_req_a, ack_a, busy_a, word_done_a;
    // Instance B signals
    logic [3:0]  in_data_b;
    logic        in_valid_b;
    logic        in_ready_b, out_data_b, out_req_b, ack_b, busy_b, word_done_b;

    // Responder controls for instance A
    logic dly_mode  = 1'b0;
    logic force_hi  = 1'b0;
    logic ack_dly   = 1'b0;
    logic chk_proto = 1'b0;

    assign ack_a = force_hi ? 1'b1 : (dly_mode ? ack_dly : out_req_a);
    assign ack_b = out_req_b;

    p4bd_serializer dut_a (
        .clk(clk), .reset(reset), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .out_data(out_data_a), .out_req(out_req_a),
        .out_ack(ack_a), .busy(busy_a), .word_done(word_done_a)
    );

    p4bd_serializer #(.WIDTH(4), .SYNC_STAGES(3), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .out_data(out_data_b), .out_req(out_req_b),
        .out_ack(ack_b), .busy(busy_b), .word_done(word_done_b)
    );

    bit exp_a[$];
    bit exp_b[$];
    bit seq_a[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                      1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model of the 2-stage ack synchronizer of instance A
    logic [1:0] msync = 2'b00;
    always @(posedge clk) begin
        if (reset) msync <= 2'b00;
        else       msync <= {msync[0], ack_a};
    end

    // Random-delay responder: ack follows req after 1..10 cycles
    initial begin
        forever begin
            @(negedge clk);
            if (dly_mode && ack_dly !== out_req_a) begin
                repeat ($urandom_range(9, 0)) @(negedge clk);
                ack_dly = out_req_a;
            end
        end
    end

    // Monitor A: scoreboard on req rise plus bundled-data protocol checks
    logic prev_req_a = 1'b0, prev_data_a = 1'b0, prev_acks = 1'b0;
    int   rise_a = 0, done_a = 0;
    always @(negedge clk) begin
        if (out_req_a && !prev_req_a) begin
            rise_a <= rise_a + 1;
            if (exp_a.size() == 0) check("bit_a_extra", exp_a.size(), 1);
            else check("bit_a", int'(out_data_a), int'(exp_a.pop_front()));
            if (chk_proto) check("setup_stable", int'(out_data_a), int'(prev_data_a));
        end
        if (chk_proto && !out_req_a && prev_req_a)
            check("req_fall_after_ack", int'(prev_acks), 1);
        if (chk_proto && out_data_a !== prev_data_a)
            check("data_change_quiet", int'({prev_req_a, prev_acks}), 0);
        if (word_done_a) done_a <= done_a + 1;
        prev_req_a  <= out_req_a;
        prev_data_a <= out_data_a;
        prev_acks   <= msync[1];
    end

    // Monitor B: scoreboard and bit period on req rise
    logic prev_req_b = 1'b0;
    int   rise_b = 0, last_rise_b = 0;
    always @(negedge clk) begin
        if (out_req_b && !prev_req_b) begin
            rise_b <= rise_b + 1;
            last_rise_b <= cyc;
            if (rise_b > 0) check("period_b", cyc - last_rise_b, 9);
            if (exp_b.size() == 0) check("bit_b_extra", exp_b.size(), 1);
            else check("bit_b", int'(out_data_b), int'(exp_b.pop_front()));
        end
        prev_req_b <= out_req_b;
    end

    task automatic push_a(input logic [12:0] w);
        for (int i = 0; i < 13; i++) exp_a.push_back(w[i]);
    endtask

    task automatic wait_done_a(input int limit, output int n);
        n = 0;
        while (word_done_a !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("word_done_seen_a", int'(word_done_a), 1);
    endtask

    initial begin
        int n;
        int base;
        int d0;
        in_valid_a = 1'b0; in_data_a = 13'd0;
        in_valid_b = 1'b0; in_data_b = 4'd0;

        // Reset held for three cycles, then idle
        repeat (3) begin
            @(negedge clk);
            check("rst_req", int'(out_req_a), 0);
            check("rst_busy", int'(busy_a), 0);
            check("rst_ready", int'(in_ready_a), 0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst_a", int'(in_ready_a), 1);
        check("ready_after_rst_b", int'(in_ready_b), 1);
        repeat (5) @(negedge clk);
        check("idle_no_req", rise_a, 0);
        check("idle_busy", int'(busy_a), 0);

        // Default word with the instant responder, latency to word_done
        foreach (seq_a[i]) exp_a.push_back(seq_a[i]);
        in_data_a = 13'b1101001101101; in_valid_a = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        check("accept_busy", int'(busy_a), 1);
        check("accept_ready", int'(in_ready_a), 0);
        check("setup_no_req", int'(out_req_a), 0);
        @(negedge clk);
        check("req_rise_T1", int'(out_req_a), 1);
        wait_done_a(200, n);
        check("done_latency", n + 1, 91);
        @(negedge clk);
        check("done_one_cycle", int'(word_done_a), 0);
        check("rises_word1", rise_a, 13);
        check("queue_empty1", exp_a.size(), 0);

        // Same word with random-delay responder and protocol checks
        dly_mode = 1'b1; chk_proto = 1'b1;
        foreach (seq_a[i]) exp_a.push_back(seq_a[i]);
        in_data_a = 13'b1101001101101; in_valid_a = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        wait_done_a(1000, n);
        @(negedge clk);
        check("rises_word2", rise_a, 26);
        check("queue_empty2", exp_a.size(), 0);
        chk_proto = 1'b0; dly_mode = 1'b0;

        // Back-to-back words with in_valid held high
        push_a(13'h1FFF);
        in_data_a = 13'h1FFF; in_valid_a = 1'b1;
        @(negedge clk);
        check("b2b_acc1", int'(in_ready_a), 0);
        in_data_a = 13'h0000;
        push_a(13'h0000);
        wait_done_a(300, n);
        check("b2b_gap_busy", int'(busy_a), 0);
        check("b2b_gap_ready", int'(in_ready_a), 1);
        @(negedge clk);
        check("b2b_acc2_busy", int'(busy_a), 1);
        check("b2b_acc2_ready", int'(in_ready_a), 0);
        in_valid_a = 1'b0;
        wait_done_a(300, n);
        @(negedge clk);
        check("rises_b2b", rise_a, 52);
        check("queue_empty_b2b", exp_a.size(), 0);

        // Reset in the middle of a word, then restart with ack stuck high
        base = rise_a;
        push_a(13'h15A5);
        in_data_a = 13'h15A5; in_valid_a = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        n = 0;
        while (rise_a < base + 6 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached", rise_a, base + 6);
        check("mid_in_reqhi", int'(out_req_a), 1);
        check("mid_ack_hi", int'(ack_a), 1);
        d0 = done_a;
        reset = 1'b1; force_hi = 1'b1;
        exp_a.delete();
        @(negedge clk);
        check("mid_rst_req", int'(out_req_a), 0);
        check("mid_rst_busy", int'(busy_a), 0);
        check("mid_rst_done", int'(word_done_a), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("no_done_after_rst", done_a, d0);
        check("ready_ack_hi", int'(in_ready_a), 1);
        check("rises_frozen", rise_a, base + 6);
        push_a(13'h0001);
        in_data_a = 13'h0001; in_valid_a = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("hold_setup_req", int'(out_req_a), 0);
            check("hold_setup_busy", int'(busy_a), 1);
        end
        force_hi = 1'b0;
        wait_done_a(300, n);
        @(negedge clk);
        check("rises_after_rst", rise_a, base + 6 + 13);
        check("queue_empty_rst", exp_a.size(), 0);
        check("done_count_rst", done_a, d0 + 1);

        // Instance B: 4 bits, MSB first, 3 sync stages
        exp_b.push_back(1'b1); exp_b.push_back(1'b0);
        exp_b.push_back(1'b0); exp_b.push_back(1'b0);
        in_data_b = 4'b1000; in_valid_b = 1'b1;
        @(negedge clk);
        in_valid_b = 1'b0;
        n = 0;
        while (word_done_b !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b_done_latency", n, 36);
        @(negedge clk);
        check("b_rises", rise_b, 4);
        check("b_queue_empty", exp_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
